// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared constants for the seven-segment scan driver.
//   - Active-low glyphs {g,f,e,d,c,b,a} for digits 0-9, minus, blank, error.
//   - Character class used to select between digit, minus and blank glyphs.
//   - Anode count and maximum window offset.
package seg_scan_pkg;

    localparam int NUM_AN  = 4;   // physical digits on the display
    localparam int WIN_MAX = 2;   // window offset range 0..WIN_MAX
    localparam int NPOS    = 6;   // p0..p4 digits, p5 sign

    localparam logic [6:0] GLYPH_0     = 7'b1000000;
    localparam logic [6:0] GLYPH_1     = 7'b1111001;
    localparam logic [6:0] GLYPH_2     = 7'b0100100;
    localparam logic [6:0] GLYPH_3     = 7'b0110000;
    localparam logic [6:0] GLYPH_4     = 7'b0011001;
    localparam logic [6:0] GLYPH_5     = 7'b0010010;
    localparam logic [6:0] GLYPH_6     = 7'b0000010;
    localparam logic [6:0] GLYPH_7     = 7'b1111000;
    localparam logic [6:0] GLYPH_8     = 7'b0000000;
    localparam logic [6:0] GLYPH_9     = 7'b0010000;
    localparam logic [6:0] GLYPH_MINUS = 7'b0111111;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
    localparam logic [6:0] GLYPH_ERR   = 7'b0000110;

    typedef enum logic [1:0] {
        CLS_DIGIT = 2'd0,
        CLS_MINUS = 2'd1,
        CLS_BLANK = 2'd2
    } char_cls_e;

    // Non-BCD nibbles render as 'E' so a converter fault is visible.
    function automatic logic [6:0] digit_glyph(input logic [3:0] d);
        case (d)
            4'd0:    digit_glyph = GLYPH_0;
            4'd1:    digit_glyph = GLYPH_1;
            4'd2:    digit_glyph = GLYPH_2;
            4'd3:    digit_glyph = GLYPH_3;
            4'd4:    digit_glyph = GLYPH_4;
            4'd5:    digit_glyph = GLYPH_5;
            4'd6:    digit_glyph = GLYPH_6;
            4'd7:    digit_glyph = GLYPH_7;
            4'd8:    digit_glyph = GLYPH_8;
            4'd9:    digit_glyph = GLYPH_9;
            default: digit_glyph = GLYPH_ERR;
        endcase
    endfunction

endpackage

// File: rtl/seg_scan_if.sv
// seg_scan_if: control and display bundle of the scan driver.
//   load/bcd_in/neg_in       : capture strobe, 5 BCD nibbles ([3:0]=units), sign
//   scroll_left/scroll_right : single-cycle window move pulses
//   an/seg                   : active-low anodes (an[0]=rightmost), {g..a} segments
//   win_off                  : current window offset 0..2
// master = upstream driver / bench, slave = seg_scan_driver.
interface seg_scan_if;
    logic        load;
    logic [19:0] bcd_in;
    logic        neg_in;
    logic        scroll_left;
    logic        scroll_right;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [1:0]  win_off;

    modport master (
        output load, bcd_in, neg_in, scroll_left, scroll_right,
        input  an, seg, win_off
    );

    modport slave (
        input  load, bcd_in, neg_in, scroll_left, scroll_right,
        output an, seg, win_off
    );
endinterface

// File: rtl/seg7_decode.sv
// seg7_decode: combinational glyph lookup.
//   i_nib : BCD nibble (used only for CLS_DIGIT; >9 gives 'E')
//   i_cls : character class (digit / minus / blank)
//   o_seg : active-low {g,f,e,d,c,b,a}
module seg7_decode
    import seg_scan_pkg::*;
(
    input  logic [3:0] i_nib,
    input  char_cls_e  i_cls,
    output logic [6:0] o_seg
);
    always_comb begin
        case (i_cls)
            CLS_DIGIT: o_seg = digit_glyph(i_nib);
            CLS_MINUS: o_seg = GLYPH_MINUS;
            default:   o_seg = GLYPH_BLANK;
        endcase
    end
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: latches a signed 5-digit BCD value and time-multiplexes a
// scrollable 4-of-6 window of it onto a 4-digit common-anode display.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : seg_scan_if.slave (load/bcd_in/neg_in/scroll_* in,
//                an/seg/win_off out)
// Parameters: REFRESH_DIV cycles per anode (>= 2), NDIG BCD digits (5).
// Build option: define SEG_LZB_EN for leading-zero blanking with a floating
// minus sign; otherwise every digit is shown and the sign sits at p5.
module seg_scan_driver
    import seg_scan_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int NDIG        = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    seg_scan_if.slave  bus
);
    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [DIV_W-1:0]    r_div;
    logic [1:0]          r_idx;
    logic [1:0]          r_win;
    logic [4*NDIG-1:0]   r_val;
    logic                r_neg;
    logic [NUM_AN-1:0]   r_an;
    logic [6:0]          r_seg;

    logic                w_tc;
    logic                w_left;
    logic                w_right;
    logic [2:0]          w_pos;
    logic [3:0]          w_nib;
    logic                w_any;
    logic [2:0]          w_msd;
    logic [2:0]          w_sign_pos;
    char_cls_e           w_cls;
    logic [6:0]          w_seg;

    assign w_tc    = (r_div == DIV_W'(REFRESH_DIV - 1));
    // Opposing pulses in one cycle cancel.
    assign w_left  = bus.scroll_left  & ~bus.scroll_right;
    assign w_right = bus.scroll_right & ~bus.scroll_left;

    // Refresh divider and anode index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
            r_idx <= '0;
        end else if (w_tc) begin
            r_div <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    // Value capture and window offset; load and scroll are independent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_val <= '0;
            r_neg <= 1'b0;
            r_win <= '0;
        end else begin
            if (bus.load) begin
                r_val <= bus.bcd_in[4*NDIG-1:0];
                r_neg <= bus.neg_in;
            end
            if (w_left && r_win != 2'(WIN_MAX))
                r_win <= r_win + 2'd1;
            else if (w_right && r_win != 2'd0)
                r_win <= r_win - 2'd1;
        end
    end

    // Position currently on the active anode, and its nibble.
    assign w_pos = {1'b0, r_idx} + {1'b0, r_win};

    always_comb begin
        w_nib = 4'd0;
        for (int i = 0; i < NDIG; i++)
            if (w_pos == 3'(i)) w_nib = r_val[4*i +: 4];
    end

    // Most significant nonzero digit; ascending scan so the highest wins.
    always_comb begin
        w_any = 1'b0;
        w_msd = 3'd0;
        for (int i = 0; i < NDIG; i++) begin
            if (r_val[4*i +: 4] != 4'd0) begin
                w_any = 1'b1;
                w_msd = 3'(i);
            end
        end
        // A zero value keeps its units digit, so the sign goes to p1.
        w_sign_pos = w_any ? w_msd + 3'd1 : 3'd1;
    end

    always_comb begin
        w_cls = CLS_DIGIT;
`ifdef SEG_LZB_EN
        if (r_neg && w_pos == w_sign_pos)
            w_cls = CLS_MINUS;
        else if (w_pos == 3'(NPOS - 1))
            w_cls = CLS_BLANK;
        else if (w_pos != 3'd0 && (!w_any || w_pos > w_msd))
            w_cls = CLS_BLANK;
`else
        if (w_pos == 3'(NPOS - 1))
            w_cls = r_neg ? CLS_MINUS : CLS_BLANK;
`endif
    end

    seg7_decode u_dec (
        .i_nib (w_nib),
        .i_cls (w_cls),
        .o_seg (w_seg)
    );

    // Anode and segments registered together so they switch on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an  <= '1;
            r_seg <= GLYPH_BLANK;
        end else begin
            r_an  <= ~(NUM_AN'(1) << r_idx);
            r_seg <= w_seg;
        end
    end

    assign bus.an      = r_an;
    assign bus.seg     = r_seg;
    assign bus.win_off = r_win;

    // w_sign_pos is only consumed by the blanking build.
    logic w_unused;
    assign w_unused = ^w_sign_pos;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver with REFRESH_DIV=4. Stimulus pushes expected
// anode/segment/offset values into a queue; a monitor on the falling edge
// pops and compares them against the outputs.
module tb_seg_scan_driver;

    localparam int DIV = 4;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                           S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                           SM = 7'b0111111, SB = 7'b1111111, SE = 7'b0000110;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    seg_scan_if bus ();

    seg_scan_driver #(.REFRESH_DIV(DIV), .NDIG(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] an;
        logic [6:0] seg;
        logic [1:0] win;
        bit         c_an;
        bit         c_seg;
        bit         c_win;
    } exp_t;

    exp_t q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   n_to    = 0;

    // Monitor: drains every expectation queued during the preceding high phase.
    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            if (e.c_an) begin
                n_total++;
                if (bus.an === e.an) n_pass++;
                else $display("FAIL %s an: got %b want %b", e.name, bus.an, e.an);
            end
            if (e.c_seg) begin
                n_total++;
                if (bus.seg === e.seg) n_pass++;
                else $display("FAIL %s seg: got %b want %b", e.name, bus.seg, e.seg);
            end
            if (e.c_win) begin
                n_total++;
                if (bus.win_off === e.win) n_pass++;
                else $display("FAIL %s win_off: got %0d want %0d", e.name, bus.win_off, e.win);
            end
        end
    end

    function automatic void push_exp(input string name, input logic [3:0] an,
                                     input logic [6:0] seg, input logic [1:0] win,
                                     input bit c_an, input bit c_seg, input bit c_win);
        exp_t e;
        e.name = name; e.an = an; e.seg = seg; e.win = win;
        e.c_an = c_an; e.c_seg = c_seg; e.c_win = c_win;
        q.push_back(e);
    endfunction

    // All tasks start and end at posedge+1.
    task automatic drive(input logic ld, input logic [19:0] v, input logic ng,
                         input logic sl, input logic sr);
        bus.load = ld; bus.bcd_in = v; bus.neg_in = ng;
        bus.scroll_left = sl; bus.scroll_right = sr;
        @(posedge clk); #1;
        bus.load = 1'b0; bus.scroll_left = 1'b0; bus.scroll_right = 1'b0;
        // one more edge so the registered seg reflects the new state
        @(posedge clk); #1;
    endtask

    task automatic wait_slot(input int k, input string name);
        logic [3:0] tgt;
        int n;
        tgt = ~(4'b0001 << k);
        n = 0;
        while (bus.an !== tgt && n < 24) begin
            @(posedge clk); #1;
            n++;
        end
        if (bus.an !== tgt) begin
            n_to++;
            $display("FAIL %s slot%0d timeout: an=%b want %b", name, k, bus.an, tgt);
        end
    endtask

    task automatic show4(input string name, input logic [6:0] s0, input logic [6:0] s1,
                         input logic [6:0] s2, input logic [6:0] s3);
        logic [6:0] s [4];
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        for (int k = 0; k < 4; k++) begin
            wait_slot(k, name);
            push_exp($sformatf("%s_an%0d", name, k), '0, s[k], '0, 0, 1, 0);
        end
    endtask

    task automatic chk_win(input string name, input logic [1:0] w);
        push_exp(name, '0, '0, w, 0, 0, 1);
    endtask

    initial begin
        bus.load = 1'b0; bus.bcd_in = '0; bus.neg_in = 1'b0;
        bus.scroll_left = 1'b0; bus.scroll_right = 1'b0;

        // Reset state, then anode scan after release.
        repeat (2) @(posedge clk);
        #1;
        push_exp("reset", 4'b1111, SB, 2'd0, 1, 1, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            logic [3:0] a;
            @(posedge clk); #1;
            a = ~(4'b0001 << ((k - 1) / DIV));
            push_exp($sformatf("scan%0d", k), a, '0, '0, 1, 0, 0);
        end

        // Plain value, window 0.
        drive(1, 20'h12345, 0, 0, 0);
        show4("v12345", S5, S4, S3, S2);

        // Scroll to saturation at 2.
        drive(0, '0, 0, 1, 0);
        drive(0, '0, 0, 1, 0);
        drive(0, '0, 0, 1, 0);
        chk_win("left_sat", 2'd2);
        show4("win2", S3, S2, S1, SB);

        // Opposing pulses cancel.
        drive(0, '0, 0, 1, 1);
        chk_win("both", 2'd2);

        drive(0, '0, 0, 0, 1);
        chk_win("right1", 2'd1);
        drive(0, '0, 0, 0, 1);
        drive(0, '0, 0, 0, 1);
        chk_win("right_sat", 2'd0);

        // Load and scroll on the same edge; nibble A shows 'E'.
        drive(1, 20'h0A001, 0, 1, 0);
        chk_win("load_scroll", 2'd1);
`ifdef SEG_LZB_EN
        show4("vErr", S0, S0, SE, SB);
`else
        show4("vErr", S0, S0, SE, S0);
`endif

        // Negative full-width value: sign at p5 in both builds.
        drive(1, 20'h12345, 1, 1, 0);
        chk_win("neg_win", 2'd2);
        show4("neg12345", S3, S2, S1, SM);

        drive(0, '0, 0, 0, 1);
        drive(0, '0, 0, 0, 1);
        chk_win("back0", 2'd0);

        drive(1, 20'h00042, 1, 0, 0);
`ifdef SEG_LZB_EN
        show4("neg42", S2, S4, SM, SB);
`else
        show4("neg42", S2, S4, S0, S0);
`endif

        drive(1, 20'h00000, 1, 0, 0);
`ifdef SEG_LZB_EN
        show4("negzero", S0, SM, SB, SB);
`else
        show4("negzero", S0, S0, S0, S0);
`endif

        // Asynchronous reset in the middle of the idx=2 slot.
        drive(1, 20'h12345, 0, 1, 0);
        wait_slot(2, "midrst");
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        push_exp("midrst", 4'b1111, SB, 2'd0, 1, 1, 1);
        @(posedge clk); #1;
        push_exp("midrst_hold", 4'b1111, SB, 2'd0, 1, 1, 1);
        rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            push_exp($sformatf("restart%0d", k), (k <= 4) ? 4'b1110 : 4'b1101,
                     S0, '0, 1, (k == 1), 0);
        end

        @(negedge clk);
        @(posedge clk); #1;
        $display("%0d/%0d checks passed", n_pass, n_total + n_to);
        $finish;
    end

endmodule
